// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared definitions for the iterative RV32M multiply/divide unit.
//   - MDU_F3_* : funct3 codes of the M-extension OP instructions.
//   - MDU_ST_* : 2-bit FSM state encodings.
//   - MDU_ITERS: number of radix-2 steps per operation.
//   - mdu_mode_e / mdu_dec_t / mdu_decode(): per-funct3 operation attributes.
package muldiv_unit_pkg;

  localparam int MDU_ITERS = 32;

  localparam logic [2:0] MDU_F3_MUL    = 3'd0;
  localparam logic [2:0] MDU_F3_MULH   = 3'd1;
  localparam logic [2:0] MDU_F3_MULHSU = 3'd2;
  localparam logic [2:0] MDU_F3_MULHU  = 3'd3;
  localparam logic [2:0] MDU_F3_DIV    = 3'd4;
  localparam logic [2:0] MDU_F3_DIVU   = 3'd5;
  localparam logic [2:0] MDU_F3_REM    = 3'd6;
  localparam logic [2:0] MDU_F3_REMU   = 3'd7;

  localparam logic [1:0] MDU_ST_IDLE = 2'd0;
  localparam logic [1:0] MDU_ST_CALC = 2'd1;
  localparam logic [1:0] MDU_ST_FIN  = 2'd2;
  localparam logic [1:0] MDU_ST_DONE = 2'd3;

  typedef enum logic {
    MDU_MODE_MUL = 1'b0,
    MDU_MODE_DIV = 1'b1
  } mdu_mode_e;

  // sel_upper picks the high product word for multiplies and the
  // remainder (instead of the quotient) for divides.
  typedef struct packed {
    mdu_mode_e mode;
    logic      op1_signed;
    logic      op2_signed;
    logic      sel_upper;
  } mdu_dec_t;

  function automatic mdu_dec_t mdu_decode(input logic [2:0] f3);
    mdu_dec_t d;
    d = '{mode: MDU_MODE_MUL, op1_signed: 1'b0, op2_signed: 1'b0, sel_upper: 1'b0};
    case (f3)
      MDU_F3_MUL:    d.sel_upper = 1'b0;
      MDU_F3_MULH:   begin
        d.op1_signed = 1'b1;
        d.op2_signed = 1'b1;
        d.sel_upper  = 1'b1;
      end
      MDU_F3_MULHSU: begin
        d.op1_signed = 1'b1;
        d.sel_upper  = 1'b1;
      end
      MDU_F3_MULHU:  d.sel_upper = 1'b1;
      MDU_F3_DIV:    begin
        d.mode       = MDU_MODE_DIV;
        d.op1_signed = 1'b1;
        d.op2_signed = 1'b1;
      end
      MDU_F3_DIVU:   d.mode = MDU_MODE_DIV;
      MDU_F3_REM:    begin
        d.mode       = MDU_MODE_DIV;
        d.op1_signed = 1'b1;
        d.op2_signed = 1'b1;
        d.sel_upper  = 1'b1;
      end
      MDU_F3_REMU:   begin
        d.mode      = MDU_MODE_DIV;
        d.sel_upper = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_unit_mdu_step.sv
// mdu_step
//   Combinational single radix-2 step shared by multiply and divide.
//   Accumulator layout (2*XLEN+1 bits):
//     multiply: {carry, partial-high[XLEN-1:0], multiplier/product-low[XLEN-1:0]}
//     divide  : {remainder[XLEN:0], dividend/quotient[XLEN-1:0]}
// Ports
//   acc      in  2*XLEN+1  current accumulator
//   operand  in  XLEN      multiplicand magnitude (mul) or divisor magnitude (div)
//   mode     in  1         MDU_MODE_MUL / MDU_MODE_DIV
//   acc_next out 2*XLEN+1  accumulator after one step; in divide mode the new
//                          quotient bit is shifted in at acc_next[0]
module mdu_step
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN:0]  acc,
  input  logic [XLEN-1:0]  operand,
  input  mdu_mode_e        mode,
  output logic [2*XLEN:0]  acc_next
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_shift;
  logic            div_ge;
  logic [XLEN:0]   div_rem;

  // NOTE: every signal below is assigned on every path through the block,
  // so this stays purely combinational and no latch is inferred.
  always_comb begin
    // Shift-add: add the multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
            + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});

    // Restoring division: shift the next dividend bit into the remainder,
    // subtract the divisor only if it fits.
    div_shift = acc[2*XLEN:XLEN-1];
    div_ge    = (div_shift >= {2'b00, operand});
    div_rem   = div_ge ? (div_shift[XLEN:0] - {1'b0, operand}) : div_shift[XLEN:0];

    if (mode == MDU_MODE_DIV) begin
      acc_next = {div_rem, acc[XLEN-2:0], div_ge};
    end else begin
      acc_next = {1'b0, mul_sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. Operands are
//   converted to magnitudes at acceptance, 32 radix-2 steps run in CALC, the
//   sign fix-up and word select happen in FIN, and DONE commits the result
//   with a one-cycle done pulse on the following cycle. busy stalls the
//   front of the pipeline for the whole operation including the done cycle.
// Parameters
//   XLEN          operand/result width (only 32 is supported)
//   FAST_SPECIAL  1: divide-by-zero and signed overflow skip the iteration
// Ports
//   clk     in   1     rising-edge clock
//   rst     in   1     asynchronous active-high reset
//   start   in   1     request, accepted only when idle and not flushed
//   funct3  in   3     M-extension operation select
//   op1     in   XLEN  rs1 value, sampled at the accepting edge
//   op2     in   XLEN  rs2 value, sampled at the accepting edge
//   flush   in   1     kill; aborts CALC/FIN, blocks acceptance
//   busy    out  1     high from the accepting edge through the done cycle
//   done    out  1     single-cycle completion pulse
//   result  out  XLEN  registered result, held until the next done
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0]      CNT_LAST = 5'(MDU_ITERS - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  // Registered state
  logic [1:0]        state;
  logic [4:0]        cnt;
  mdu_dec_t          dec_q;
  logic              s1_q;      // effective sign of op1 (0 when treated unsigned)
  logic              s2_q;      // effective sign of op2
  logic              dz_q;      // divisor was zero
  logic [2*XLEN:0]   acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   res_q;     // staged result, committed to result in DONE

  // Acceptance-side decode
  mdu_dec_t          dec_in;
  logic              neg1;
  logic              neg2;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_val;
  logic              accept;

  // Finish-side fix-up
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_val;

  logic [2*XLEN:0]   acc_next;

  mdu_step #(.XLEN(XLEN)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .mode     (dec_q.mode),
    .acc_next (acc_next)
  );

  always_comb begin
    dec_in = mdu_decode(funct3);
    neg1   = dec_in.op1_signed & op1[XLEN-1];
    neg2   = dec_in.op2_signed & op2[XLEN-1];
    mag1   = neg1 ? -op1 : op1;
    mag2   = neg2 ? -op2 : op2;

    div_zero = (op2 == '0);
    div_ovf  = dec_in.op1_signed & (op1 == MIN_NEG) & (op2 == '1);
    special  = (dec_in.mode == MDU_MODE_DIV) & (div_zero | div_ovf);

    if (div_zero) begin
      special_val = dec_in.sel_upper ? op1 : '1;
    end else begin
      special_val = dec_in.sel_upper ? '0 : MIN_NEG;
    end

    // The done cycle still blocks acceptance even though the FSM is idle.
    accept = start & ~flush & (state == MDU_ST_IDLE) & ~done;

    // Sign fix-up. A zero divisor keeps the all-ones quotient un-negated;
    // the remainder always takes the dividend's sign.
    prod = (s1_q ^ s2_q) ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
    quo  = ((s1_q ^ s2_q) & ~dz_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    if (dec_q.mode == MDU_MODE_DIV) begin
      fin_val = dec_q.sel_upper ? rem : quo;
    end else begin
      fin_val = dec_q.sel_upper ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

  assign busy = (state != MDU_ST_IDLE) | done;

  // NOTE: all datapath registers are reset along with the control state so
  // an aborted operation leaves no stale operand or accumulator behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MDU_ST_IDLE;
      cnt    <= '0;
      dec_q  <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      dz_q   <= 1'b0;
      acc_q  <= '0;
      opnd_q <= '0;
      res_q  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge values of the others regardless of statement order.
      done <= 1'b0;
      case (state)
        MDU_ST_IDLE: begin
          if (accept) begin
            dec_q <= dec_in;
            s1_q  <= neg1;
            s2_q  <= neg2;
            dz_q  <= div_zero;
            cnt   <= '0;
            if (FAST_SPECIAL && special) begin
              res_q <= special_val;
              state <= MDU_ST_DONE;
            end else begin
              // Divide iterates over the dividend; multiply over the multiplier.
              acc_q  <= {{(XLEN+1){1'b0}}, (dec_in.mode == MDU_MODE_DIV) ? mag1 : mag2};
              opnd_q <= (dec_in.mode == MDU_MODE_DIV) ? mag2 : mag1;
              state  <= MDU_ST_CALC;
            end
          end
        end
        MDU_ST_CALC: begin
          if (flush) begin
            state <= MDU_ST_IDLE;
          end else begin
            acc_q <= acc_next;
            cnt   <= cnt + 5'd1;
            if (cnt == CNT_LAST) begin
              state <= MDU_ST_FIN;
            end
          end
        end
        MDU_ST_FIN: begin
          if (flush) begin
            state <= MDU_ST_IDLE;
          end else begin
            res_q <= fin_val;
            state <= MDU_ST_DONE;
          end
        end
        MDU_ST_DONE: begin
          // A flush here is ignored: the pulse is emitted and the pipeline
          // drops it.
          result <= res_q;
          done   <= 1'b1;
          state  <= MDU_ST_IDLE;
        end
        default: state <= MDU_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit. Two instances (FAST_SPECIAL=1 and 0)
//   share the stimulus. Each issued operation pushes its expected result and
//   expected done cycle into per-instance queues; a monitor pops and compares
//   whenever an instance raises done.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;
  localparam int         NORM_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy_f, done_f, busy_s, done_s;
  logic [31:0] result_f, result_s;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t q_f[$];
  exp_t q_s[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_fast (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
    .flush(flush), .busy(busy_f), .done(done_f), .result(result_f)
  );

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
    .flush(flush), .busy(busy_s), .done(done_s), .result(result_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on sign/zero-extended operands
  // plus the RISC-V special-case rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] xa, xb, p;
    int          sa, sb;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    xa  = {32'b0, a};
    xb  = {32'b0, b};
    if (f3 == F_MULH || f3 == F_MULHSU) xa = {{32{a[31]}}, a};
    if (f3 == F_MULH) xb = {{32{b[31]}}, b};
    p = xa * xb;
    case (f3)
      F_MUL:  return p[31:0];
      F_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      F_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM:  begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      F_REMU: return (b == 0) ? a : a % b;
      default: return p[63:32];
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 0) ||
                     (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Drive start for one cycle (edge E0 follows this negedge) and record
  // expectations. Returns at the negedge after E0.
  task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int lat_f);
    exp_t e;
    int   e0;
    e0    = cyc + 1;
    lat_f = is_special(f3, a, b) ? 1 : NORM_LAT;
    e.res = ref_model(f3, a, b);
    e.due = e0 + lat_f;
    q_f.push_back(e);
    e.due = e0 + NORM_LAT;
    q_s.push_back(e);
    last_res = e.res;
    funct3 = f3; op1 = a; op2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start_only(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3 = f3; op1 = a; op2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy samples per instance until both are idle; bounded.
  task automatic wait_idle(input int want_f, input int want_s, input string tag);
    int nf, ns, guard;
    nf = 0; ns = 0; guard = 0;
    while ((busy_f || busy_s) && guard < 80) begin
      nf += int'(busy_f);
      ns += int'(busy_s);
      guard++;
      @(negedge clk);
    end
    check({tag, " busy_cycles_fast"}, 64'(nf), 64'(want_f));
    check({tag, " busy_cycles_slow"}, 64'(ns), 64'(want_s));
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int lat;
    issue_op(f3, a, b, lat);
    wait_idle(lat + 1, NORM_LAT + 1, tag);
  endtask

  // Monitor: compare whenever an instance presents done.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (done_f) begin
        if (q_f.size() == 0) begin
          check("fast unexpected_done", 64'(done_f), 64'(0));
        end else begin
          e = q_f.pop_front();
          check("fast result", 64'(result_f), 64'(e.res));
          check("fast done_cycle", 64'(cyc), 64'(e.due));
          check("fast busy_in_done", 64'(busy_f), 64'(1));
        end
      end
      if (done_s) begin
        if (q_s.size() == 0) begin
          check("slow unexpected_done", 64'(done_s), 64'(0));
        end else begin
          e = q_s.pop_front();
          check("slow result", 64'(result_s), 64'(e.res));
          check("slow done_cycle", 64'(cyc), 64'(e.due));
          check("slow busy_in_done", 64'(busy_s), 64'(1));
        end
      end
    end
  end

  initial begin
    int          lat;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op1 = '0; op2 = '0;
    repeat (2) @(negedge clk);
    check("reset busy_fast", 64'(busy_f), 64'(0));
    check("reset done_fast", 64'(done_f), 64'(0));
    check("reset result_fast", 64'(result_f), 64'(0));
    check("reset busy_slow", 64'(busy_s), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed operations
    run_op(F_MUL,    32'd7,          32'hFFFF_FFFD, "mul_neg");
    run_op(F_MULH,   32'h8000_0000,  32'h8000_0000, "mulh_min");
    run_op(F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu_max");
    run_op(F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhsu_max");
    run_op(F_DIV,    32'hFFFF_FFF9,  32'd2,         "div_neg");
    run_op(F_REM,    32'hFFFF_FFF9,  32'd2,         "rem_neg");
    run_op(F_DIVU,   32'd100,        32'd7,         "divu");
    run_op(F_REMU,   32'd100,        32'd7,         "remu");
    run_op(F_DIV,    32'd5,          32'd0,         "div_zero");
    run_op(F_REM,    32'd5,          32'd0,         "rem_zero");
    run_op(F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");
    run_op(F_REM,    32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");
    run_op(F_DIV,    32'hFFFF_FFF0,  32'd0,         "div_zero_negdividend");
    run_op(F_REMU,   32'hDEAD_BEEF,  32'd0,         "remu_zero");

    // Flush in CALC at E10: no done, result unchanged, restart at E11.
    start_only(F_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy_fast", 64'(busy_f), 64'(0));
    check("flush busy_slow", 64'(busy_s), 64'(0));
    check("flush result_fast", 64'(result_f), 64'(last_res));
    check("flush result_slow", 64'(result_s), 64'(last_res));
    run_op(F_DIVU, 32'd100, 32'd7, "after_flush");

    // start and flush together while idle: nothing accepted.
    funct3 = F_MUL; op1 = 32'd3; op2 = 32'd4; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush busy_fast", 64'(busy_f), 64'(0));
    check("start_flush busy_slow", 64'(busy_s), 64'(0));

    // Flush while in DONE: the pulse still appears.
    issue_op(F_DIV, 32'd12345, 32'hFFFF_FFEF, lat);
    repeat (33) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle(1, 1, "flush_in_done");

    // start during CALC with different operands is ignored.
    issue_op(F_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    repeat (4) @(negedge clk);
    funct3 = F_DIVU; op1 = 32'd99; op2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(lat + 1 - 5, NORM_LAT + 1 - 5, "ignored_start");

    // Asynchronous reset mid-CALC, away from the clock edge.
    start_only(F_MULH, 32'h7FFF_FFFF, 32'd3);
    repeat (5) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("midreset busy_fast", 64'(busy_f), 64'(0));
    check("midreset busy_slow", 64'(busy_s), 64'(0));
    check("midreset done_fast", 64'(done_f), 64'(0));
    check("midreset result_fast", 64'(result_f), 64'(0));
    check("midreset result_slow", 64'(result_s), 64'(0));
    #12 rst = 1'b0;
    last_res = '0;
    @(negedge clk);
    run_op(F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "after_reset");

    // Randomized operations with biased operand classes.
    for (int i = 0; i < 24; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 15));
        4: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(rf3, ra, rb, "random");
    end

    repeat (40) @(negedge clk);
    check("fast queue_empty", 64'(q_f.size()), 64'(0));
    check("slow queue_empty", 64'(q_s.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
